// File: rtl/mod241_acc.sv
// Frame accumulator: sums per-chunk residues modulo 241 and presents one
// result per frame with a valid/ready handshake on both sides.
module mod241_acc #(
    parameter int N_TERMS = 84,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_residue,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_residue,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [8:0]       MODULUS   = 9'd241;
    localparam logic [CNT_W-1:0] TERM_MAX  = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    state_t           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic             in_fire;
    logic             out_fire;
    logic [8:0]       term_red;
    logic [8:0]       acc_base;
    logic [8:0]       sum;
    logic [8:0]       sum_red;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_residue = acc;
    assign out_count   = cnt;
    assign out_err     = err;

    // Both operands are below 241 after reduction, so one conditional
    // subtract is enough to bring the 9-bit sum back into range.
    always_comb begin
        term_red = {1'b0, in_residue};
        if (term_red >= MODULUS) begin
            term_red = term_red - MODULUS;
        end
        acc_base = (cnt == '0) ? 9'd0 : {1'b0, acc};
        sum      = acc_base + term_red;
        sum_red  = sum;
        if (sum >= MODULUS) begin
            sum_red = sum - MODULUS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_fire) begin
                        acc <= sum_red[7:0];
                        if (cnt != CNT_SAT) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (cnt == TERM_MAX) begin
                            err <= 1'b1;
                        end
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
